vga_scan_generator: RTL
=======================

// Module: vga_scan_generator
// PURPOSE
//  Upstream neighbour of the pixel renderer: divides the system clock to a pixel tick and
//  runs horizontal/vertical scan counters. Drives pix_x/pix_y into the renderer, samples its
//  combinational r/g/b reply and registers colour with hsync/vsync so all leave on one edge.
//  Standard 640x480@60 by default, 25 MHz pixel rate from a 50 MHz clk.
// PARAMETERS
//  CLK_DIV    2    clk cycles per pixel (>=1)
//  H_VISIBLE  640  visible pixels per line
//  H_FRONT    16   horizontal front porch, pixels
//  H_SYNC     96   hsync width, pixels
//  H_BACK     48   horizontal back porch, pixels (H_TOTAL=800)
//  V_VISIBLE  480  visible lines
//  V_FRONT    10   vertical front porch, lines
//  V_SYNC     2    vsync width, lines
//  V_BACK     33   vertical back porch, lines (V_TOTAL=525)
//  SYNC_POL   0    sync active level (0 = active-low)
// PORTS
//  clk          in   1   system clock
//  rst          in   1   asynchronous reset, active-high
//  pix_x        out  11  current horizontal count, to renderer x
//  pix_y        out  11  current vertical count, to renderer y
//  r_in,g_in,b_in in 3 each  renderer colour for (pix_x,pix_y), same cycle
//  pix_en       out  1   one-clk pixel tick
//  frame_start  out  1   one-clk pulse when scan wraps to (0,0)
//  hs, vs       out  1   sync outputs to connector
//  r, g, b      out  3 each  registered colour to DAC
//  test_mode    in   1   colour-bar select (only with VGA_TEST_PATTERN_EN)
// BEHAVIOUR
//  - Reset: divider=0, h_cnt=v_cnt=0, pix_en=0, frame_start=0, r=g=b=0, hs=vs=!SYNC_POL.
//  - Divider counts 0..CLK_DIV-1; pix_en (registered) high in the clk after it hits CLK_DIV-1.
//    CLK_DIV=1: pix_en high every clk from first clk after reset release.
//  - pix_x=h_cnt, pix_y=v_cnt (11-bit, combinational from counters). Counters change only on pix_en.
//  - On a pix_en clk, edge latches from current counters: r/g/b = colour if h_cnt<H_VISIBLE &&
//    v_cnt<V_VISIBLE else 0; hs=SYNC_POL iff 656<=h_cnt<=751; vs=SYNC_POL iff 490<=v_cnt<=491
//    (bounds derived from parameters). Latency: counter value -> pins = 1 clk after tick.
//  - Same edge: h_cnt==H_TOTAL-1 -> h_cnt=0 and v_cnt++; v_cnt==V_TOTAL-1 at that point -> v_cnt=0
//    and frame_start=1 for exactly the next clk. Else h_cnt++. Between ticks outputs hold.
//  - Async rst mid-line/mid-frame: immediate return to reset values; scan restarts at (0,0),
//    first frame_start after one full frame. No partial-frame pulse.
//  - Elaboration guard: H_TOTAL, V_TOTAL <= 2047; CLK_DIV>=1.
// CONFIGURATION
//  VGA_TEST_PATTERN_EN defined: test_mode=1 replaces r_in/g_in/b_in with 8 vertical bars of
//    width H_VISIBLE/8; bar k = {r,g,b}={k[2]?7:0, k[1]?7:0, k[0]?7:0}; blanking unchanged.
//  Undefined: test_mode port present but ignored; colour always from renderer.
// STRUCTURE
//  vga_timing_pkg: H_/V_ default constants, H_TOTAL/V_TOTAL, sync start/end derivations,
//    colour width (3) and pixel typedef.
//  Sub-module pixel_clock_enable (CLK_DIV divider -> pix_en); counters, sync and colour
//    registers stay in this module.
// TESTING
//  1. Release rst, CLK_DIV=2 -> pix_en toggles 0,1,0,1; hs=vs=1; r/g/b=0 until first tick.
//  2. Run one line -> hs low for exactly 96 ticks, falling edge 1 clk after tick at h_cnt=656.
//  3. Run one frame -> vs low for 2 lines (490,491); frame_start single clk after 420000 ticks.
//  4. r_in=5 constant -> r=5 only for h<640,v<480; r=0 in porch/sync regions.
//  5. Assert rst at h_cnt=300,v_cnt=200 -> all outputs reset same clk; restart at (0,0).
//  6. VGA_TEST_PATTERN_EN, test_mode=1 -> pixel x=85 gives (0,0,7), x=600 gives (7,7,7).

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing, total/sync-bound helpers, colour width and pixel type
package vga_timing_pkg;
  localparam int CW = 3;
  localparam int CNT_W = 11;
  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BACK_DEF = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BACK_DEF = 33;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef struct packed {
    logic [CW-1:0] r;
    logic [CW-1:0] g;
    logic [CW-1:0] b;
  } pixel_t;
  function automatic int scan_total(input int vis, input int front, input int sync, input int back);
    return vis + front + sync + back;
  endfunction
  function automatic cnt_t sync_start(input int vis, input int front);
    return cnt_t'(vis + front);
  endfunction
  function automatic cnt_t sync_end(input int vis, input int front, input int sync);
    return cnt_t'(vis + front + sync - 1);
  endfunction
endpackage

// File: rtl/vga_scan_generator_pixel_clock_enable.sv
// pixel_clock_enable: divides clk by CLK_DIV into a registered one-clk pixel tick
module pixel_clock_enable #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic pix_en
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  logic [DW-1:0] div_q, div_d;
  logic pix_en_q, pix_en_d;
  // wrap the divider at CLK_DIV-1 and raise the tick for the clk that follows
  always_comb begin
    div_d = div_q == DIV_LAST ? '0 : div_q + DW'(1);
    pix_en_d = div_q == DIV_LAST;
  end
  // divider and tick registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      pix_en_q <= 1'b0;
    end else begin
      div_q <= div_d;
      pix_en_q <= pix_en_d;
    end
  end
  assign pix_en = pix_en_q;
endmodule

// File: rtl/vga_scan_generator.sv
// vga_scan_generator: VGA scan counters, sync and registered colour; VGA_TEST_PATTERN_EN adds colour bars
module vga_scan_generator
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT = H_FRONT_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BACK = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT = V_FRONT_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BACK = V_BACK_DEF,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  output logic [10:0]   pix_x,
  output logic [10:0]   pix_y,
  input  logic [CW-1:0] r_in,
  input  logic [CW-1:0] g_in,
  input  logic [CW-1:0] b_in,
  output logic          pix_en,
  output logic          frame_start,
  output logic          hs,
  output logic          vs,
  output logic [CW-1:0] r,
  output logic [CW-1:0] g,
  output logic [CW-1:0] b,
  input  logic          test_mode
);
  localparam int H_TOTAL = scan_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = scan_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_VIS = cnt_t'(H_VISIBLE);
  localparam cnt_t V_VIS = cnt_t'(V_VISIBLE);
  localparam cnt_t HS_START = sync_start(H_VISIBLE, H_FRONT);
  localparam cnt_t HS_END = sync_end(H_VISIBLE, H_FRONT, H_SYNC);
  localparam cnt_t VS_START = sync_start(V_VISIBLE, V_FRONT);
  localparam cnt_t VS_END = sync_end(V_VISIBLE, V_FRONT, V_SYNC);
  if (H_TOTAL > 2047 || V_TOTAL > 2047 || CLK_DIV < 1) begin : g_bad_cfg
    $error("vga_scan_generator: timing totals must be <= 2047 and CLK_DIV >= 1");
  end
  cnt_t h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
  logic h_wrap, v_wrap, visible;
  pixel_t col_q, col_d, src;
  pixel_clock_enable #(.CLK_DIV(CLK_DIV)) u_pix_en (
    .clk(clk),
    .rst(rst),
    .pix_en(pix_en)
  );
`ifdef VGA_TEST_PATTERN_EN
  localparam cnt_t BAR_W = cnt_t'(H_VISIBLE / 8);
  logic [2:0] bar;
  assign bar = 3'(h_cnt_q / BAR_W);
  assign src = test_mode ? {{CW{bar[2]}}, {CW{bar[1]}}, {CW{bar[0]}}} : {r_in, g_in, b_in};
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode;
  assign src = {r_in, g_in, b_in};
`endif
  // next scan position, sync levels and blanked colour; all hold between pixel ticks
  always_comb begin
    h_wrap = h_cnt_q == H_LAST;
    v_wrap = v_cnt_q == V_LAST;
    visible = h_cnt_q < H_VIS && v_cnt_q < V_VIS;
    h_cnt_d = pix_en ? (h_wrap ? '0 : h_cnt_q + cnt_t'(1)) : h_cnt_q;
    v_cnt_d = pix_en && h_wrap ? (v_wrap ? '0 : v_cnt_q + cnt_t'(1)) : v_cnt_q;
    hs_d = pix_en ? ((h_cnt_q >= HS_START && h_cnt_q <= HS_END) ? SYNC_POL : !SYNC_POL) : hs_q;
    vs_d = pix_en ? ((v_cnt_q >= VS_START && v_cnt_q <= VS_END) ? SYNC_POL : !SYNC_POL) : vs_q;
    col_d = pix_en ? (visible ? src : '0) : col_q;
    fs_d = pix_en && h_wrap && v_wrap;
  end
  // scan counters plus sync/colour/frame registers so every pin leaves on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      hs_q <= !SYNC_POL;
      vs_q <= !SYNC_POL;
      fs_q <= 1'b0;
      col_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      fs_q <= fs_d;
      col_q <= col_d;
    end
  end
  assign pix_x = h_cnt_q;
  assign pix_y = v_cnt_q;
  assign hs = hs_q;
  assign vs = vs_q;
  assign frame_start = fs_q;
  assign {r, g, b} = col_q;
endmodule
